byte_serializer_negedge_feed: RTL and testbench
===============================================

BYTE_SERIALIZER_NEGEDGE_FEED -- requirements
Module: byte_serializer_negedge_feed

Interface
REQ-001 Parameter: WIDTH, 8, number of bits per word; legal range 2..32.
REQ-002 Port: C  input  1  clock; all internal state updates on the rising edge.
REQ-003 Port: CLR_N  input  1  asynchronous active-low reset.
REQ-004 Port: DIN  input  WIDTH  parallel word to serialize.
REQ-005 Port: LOAD  input  1  word-valid; transfer occurs on a rising edge of C when LOAD=1 and RDY=1.
REQ-006 Port: HOLD  input  1  stall request; freezes shifting while high.
REQ-007 Port: RDY  output  1  ready to accept a word.
REQ-008 Port: SI_OUT  output  1  serial data to the downstream negedge shift register, MSB first.
REQ-009 Port: CE_OUT  output  1  shift enable to the downstream register, one bit per asserted cycle.
REQ-010 Port: DONE  output  1  one-cycle pulse after the last bit of a word has been presented.
REQ-011 Port: WORD_CNT  output  8  count of completed words, wraps 255->0.

Function
REQ-012 FSM states SHALL be exactly IDLE and SHIFT; a WIDTH-wide shift register SREG and a bit counter BCNT (0..WIDTH-1) are held.
REQ-013 IDLE: RDY=1, CE_OUT=0, SI_OUT=0; on a transfer, SREG<=DIN, BCNT<=0, state<=SHIFT.
REQ-014 SHIFT: SI_OUT=SREG[WIDTH-1]; CE_OUT=!HOLD (combinational from HOLD and state).
REQ-015 SHIFT, HOLD=0, BCNT<WIDTH-1: SREG shifts left with 0 fill, and BCNT increments.
REQ-016 SHIFT, HOLD=1: SREG, BCNT, state, SI_OUT frozen; CE_OUT=0.
REQ-017 RDY SHALL be 1 in SHIFT only when BCNT=WIDTH-1 and HOLD=0; otherwise 0 in SHIFT.
REQ-018 Last bit (SHIFT, BCNT=WIDTH-1, HOLD=0) with transfer: SREG<=DIN, BCNT<=0, stay SHIFT, so the next MSB follows with zero gap.
REQ-019 Last bit without transfer: state<=IDLE, SREG<=0.
REQ-020 Every last-bit cycle SHALL register DONE=1 for the following cycle and increment WORD_CNT modulo 256 on the same edge.
REQ-021 LOAD while RDY=0 SHALL be ignored and SHALL NOT corrupt SREG; the source holds DIN/LOAD until RDY.
REQ-022 SI_OUT and CE_OUT SHALL change only after rising edges of C (or HOLD changes), so both are stable at the downstream falling-edge capture.
REQ-023 Latency: transfer at rising edge k -> MSB presented during cycle k+1, last bit during cycle k+WIDTH (HOLD=0), DONE in cycle k+WIDTH+1.

Reset
REQ-024 CLR_N=0 SHALL immediately, independent of C, force state=IDLE, SREG=0, BCNT=0, DONE=0, WORD_CNT=0, giving RDY=1, CE_OUT=0, SI_OUT=0.
REQ-025 Reset asserted mid-word SHALL abandon the word with no DONE and no WORD_CNT increment; the first rising edge after CLR_N returns to 1 behaves as IDLE.

Verification
REQ-026 DIN=0xA5, LOAD one cycle, HOLD=0 -> CE_OUT high for 8 consecutive cycles, SI_OUT=1,0,1,0,0,1,0,1; downstream 8-bit negedge register reads 0xA5; DONE one pulse; WORD_CNT=1.
REQ-027 Back-to-back 0x3C then 0xC3, LOAD held high -> 16 contiguous CE_OUT cycles, SI_OUT=0011110011000011, RDY high only in cycles 8 and 16, two DONE pulses 8 cycles apart, WORD_CNT=2.
REQ-028 0xF0 with HOLD=1 for 3 cycles after bit 2 -> CE_OUT low 3 cycles, SI_OUT held at 1, serial sequence unchanged, DONE 3 cycles later than unstalled run.
REQ-029 HOLD=1 during the last bit with LOAD=1 -> RDY=0, no transfer until HOLD drops, then word accepted with zero gap.
REQ-030 CLR_N pulsed low after bit 4 of 0xFF -> RDY=1, CE_OUT=0, SI_OUT=0 asynchronously, no DONE, WORD_CNT=0; next 0x81 serializes correctly.
REQ-031 LOAD pulsed with DIN=0x00 during bit 3 of 0x55 -> ignored; output remains 01010101; 256 words -> WORD_CNT wraps to 0.

Source files
------------

// File: rtl/byte_serializer_negedge_feed.sv
// MSB-first parallel-to-serial converter feeding a downstream falling-edge shift register.
// Words are accepted on a LOAD/RDY handshake and can be chained back-to-back with no gap.
module byte_serializer_negedge_feed #(
    parameter int WIDTH = 8
) (
    input  logic             C,
    input  logic             CLR_N,
    input  logic [WIDTH-1:0] DIN,
    input  logic             LOAD,
    input  logic             HOLD,
    output logic             RDY,
    output logic             SI_OUT,
    output logic             CE_OUT,
    output logic             DONE,
    output logic [7:0]       WORD_CNT
);

    localparam int             BW       = $clog2(WIDTH);
    localparam logic [BW-1:0]  LAST_BIT = BW'(WIDTH - 1);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_sreg;
    logic [BW-1:0]    r_bcnt;
    logic             r_done;
    logic [7:0]       r_word_cnt;

    logic w_last;
    logic w_xfer;

    // The last bit is only consumed when not stalled; that is also the only
    // moment a new word may be taken while shifting, which gives zero-gap chaining.
    assign w_last   = (r_state == SHIFT) && (r_bcnt == LAST_BIT) && !HOLD;
    assign RDY      = (r_state == IDLE) || w_last;
    assign w_xfer   = LOAD && RDY;
    assign CE_OUT   = (r_state == SHIFT) && !HOLD;
    assign SI_OUT   = (r_state == SHIFT) && r_sreg[WIDTH-1];
    assign DONE     = r_done;
    assign WORD_CNT = r_word_cnt;

    // NOTE: all state here uses non-blocking assignments so every register
    // samples the pre-edge values, regardless of statement order.
    always_ff @(posedge C or negedge CLR_N) begin
        if (!CLR_N) begin
            r_state    <= IDLE;
            r_sreg     <= '0;
            r_bcnt     <= '0;
            r_done     <= 1'b0;
            r_word_cnt <= 8'd0;
        end else begin
            r_done <= w_last;
            if (w_last) begin
                r_word_cnt <= r_word_cnt + 8'd1;
            end

            case (r_state)
                IDLE: begin
                    if (w_xfer) begin
                        r_sreg  <= DIN;
                        r_bcnt  <= '0;
                        r_state <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (!HOLD) begin
                        if (r_bcnt == LAST_BIT) begin
                            if (w_xfer) begin
                                r_sreg <= DIN;
                                r_bcnt <= '0;
                            end else begin
                                r_state <= IDLE;
                                r_sreg  <= '0;
                                r_bcnt  <= '0;
                            end
                        end else begin
                            r_sreg <= {r_sreg[WIDTH-2:0], 1'b0};
                            r_bcnt <= r_bcnt + BW'(1);
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_byte_serializer_negedge_feed.sv
// Bench for byte_serializer_negedge_feed: a queue-of-bits reference model checked every
// cycle, plus directed scenarios with hand-computed expectations.
module tb_byte_serializer_negedge_feed;

    localparam int WIDTH = 8;

    logic             C;
    logic             CLR_N;
    logic [WIDTH-1:0] DIN;
    logic             LOAD;
    logic             HOLD;
    logic             RDY;
    logic             SI_OUT;
    logic             CE_OUT;
    logic             DONE;
    logic [7:0]       WORD_CNT;

    byte_serializer_negedge_feed #(.WIDTH(WIDTH)) dut (
        .C        (C),
        .CLR_N    (CLR_N),
        .DIN      (DIN),
        .LOAD     (LOAD),
        .HOLD     (HOLD),
        .RDY      (RDY),
        .SI_OUT   (SI_OUT),
        .CE_OUT   (CE_OUT),
        .DONE     (DONE),
        .WORD_CNT (WORD_CNT)
    );

    initial C = 1'b0;
    always #5 C = ~C;

    int n_vec  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: the pending serial stream is a queue of bits, each tagged
    // with whether it ends a word. Transfers append a whole word MSB first.
    bit         q_bits[$];
    bit         q_last[$];
    logic       m_done;
    logic [7:0] m_cnt;

    always @(posedge C or negedge CLR_N) begin
        bit m_rdy;
        bit popped_last;
        bit tmp;
        if (!CLR_N) begin
            q_bits.delete();
            q_last.delete();
            m_done = 1'b0;
            m_cnt  = 8'd0;
        end else begin
            m_rdy       = (q_bits.size() == 0) || (q_bits.size() == 1 && !HOLD);
            popped_last = 1'b0;
            if (q_bits.size() > 0 && !HOLD) begin
                tmp         = q_bits.pop_front();
                popped_last = q_last.pop_front();
            end
            m_done = popped_last;
            if (popped_last) m_cnt = m_cnt + 8'd1;
            if (LOAD && m_rdy) begin
                for (int i = WIDTH - 1; i >= 0; i--) begin
                    q_bits.push_back(DIN[i]);
                    q_last.push_back(i == 0);
                end
            end
        end
    end

    // Per-cycle comparison against the model, away from the rising edge.
    always @(negedge C) begin
        bit act;
        act = q_bits.size() > 0;
        check("cyc_rdy",  {31'd0, RDY},    {31'd0, (!act) || (q_bits.size() == 1 && !HOLD)});
        check("cyc_ce",   {31'd0, CE_OUT}, {31'd0, act && !HOLD});
        check("cyc_si",   {31'd0, SI_OUT}, {31'd0, act && q_bits[0]});
        check("cyc_done", {31'd0, DONE},   {31'd0, m_done});
        check("cyc_cnt",  {24'd0, WORD_CNT}, {24'd0, m_cnt});
    end

    // Downstream falling-edge shift register and run statistics.
    logic [7:0]  ds_reg;
    logic [31:0] stream;
    int cyc = 0, ce_cnt, done_cnt, run, run_max, rdy_shift, hold_hi, done_cyc, xfer_cyc;

    always @(negedge C) begin
        if (CE_OUT) ds_reg <= {ds_reg[6:0], SI_OUT};
    end

    always @(negedge C) begin
        cyc++;
        if (CE_OUT) begin
            stream = {stream[30:0], SI_OUT};
            ce_cnt++;
            run++;
            if (run > run_max) run_max = run;
        end else begin
            run = 0;
            if (SI_OUT) hold_hi++;
        end
        if (RDY && CE_OUT) rdy_shift++;
        if (DONE) begin
            done_cnt++;
            done_cyc = cyc;
        end
    end

    task automatic clear_stats();
        stream = '0; ce_cnt = 0; done_cnt = 0; run = 0; run_max = 0;
        rdy_shift = 0; hold_hi = 0; done_cyc = 0;
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge C);
            #1;
        end
    endtask

    task automatic send(input logic [7:0] w);
        bit got;
        got  = 1'b0;
        DIN  = w;
        LOAD = 1'b1;
        for (int i = 0; i < 50 && !got; i++) begin
            @(negedge C);
            #1;
            if (RDY) begin
                got      = 1'b1;
                xfer_cyc = cyc;
            end
            @(posedge C);
            #1;
        end
        LOAD = 1'b0;
        if (!got) check("send_timeout", 32'd0, 32'd1);
    endtask

    task automatic do_reset();
        @(posedge C);
        #2;
        CLR_N = 1'b0;
        @(posedge C);
        #1;
        CLR_N = 1'b1;
    endtask

    initial begin
        CLR_N = 1'b0;
        DIN   = '0;
        LOAD  = 1'b0;
        HOLD  = 1'b0;
        ds_reg = '0;
        clear_stats();
        #3;
        check("rst_rdy", {31'd0, RDY}, 32'd1);
        check("rst_ce",  {31'd0, CE_OUT}, 32'd0);
        check("rst_si",  {31'd0, SI_OUT}, 32'd0);
        check("rst_done", {31'd0, DONE}, 32'd0);
        check("rst_cnt", {24'd0, WORD_CNT}, 32'd0);
        tick(2);
        CLR_N = 1'b1;
        tick(2);

        // Single word 0xA5.
        clear_stats();
        send(8'hA5);
        tick(12);
        check("a5_stream", stream[7:0], 32'hA5);
        check("a5_ds_reg", {24'd0, ds_reg}, 32'hA5);
        check("a5_ce_run", run_max, 32'd8);
        check("a5_done",   done_cnt, 32'd1);
        check("a5_cnt",    {24'd0, WORD_CNT}, 32'd1);
        check("a5_latency", done_cyc - xfer_cyc, 32'd9);

        // Back-to-back 0x3C, 0xC3.
        do_reset();
        clear_stats();
        send(8'h3C);
        send(8'hC3);
        tick(12);
        check("b2b_stream", stream[15:0], 32'h3CC3);
        check("b2b_ce_run", run_max, 32'd16);
        check("b2b_rdy_shift", rdy_shift, 32'd2);
        check("b2b_done",   done_cnt, 32'd2);
        check("b2b_spacing", done_cyc - xfer_cyc, 32'd9);
        check("b2b_cnt",    {24'd0, WORD_CNT}, 32'd2);

        // 0xF0 stalled for 3 cycles after bit 2.
        clear_stats();
        send(8'hF0);
        tick(2);
        HOLD = 1'b1;
        tick(3);
        HOLD = 1'b0;
        tick(12);
        check("hold_stream", stream[7:0], 32'hF0);
        check("hold_ce",     ce_cnt, 32'd8);
        check("hold_si_hi",  hold_hi, 32'd3);
        check("hold_latency", done_cyc - xfer_cyc, 32'd12);

        // HOLD during the last bit while the next word is waiting.
        do_reset();
        clear_stats();
        send(8'h96);
        tick(7);
        HOLD = 1'b1;
        DIN  = 8'h5A;
        LOAD = 1'b1;
        @(negedge C);
        #1;
        check("lasthold_rdy", {31'd0, RDY}, 32'd0);
        check("lasthold_ce",  {31'd0, CE_OUT}, 32'd0);
        check("lasthold_si",  {31'd0, SI_OUT}, 32'd0);
        tick(2);
        HOLD = 1'b0;
        send(8'h5A);
        tick(12);
        check("lasthold_stream", stream[15:0], 32'h965A);
        check("lasthold_run",    run_max, 32'd9);
        check("lasthold_done",   done_cnt, 32'd2);
        check("lasthold_cnt",    {24'd0, WORD_CNT}, 32'd2);

        // Asynchronous reset mid-word of 0xFF.
        clear_stats();
        send(8'hFF);
        tick(4);
        #2;
        CLR_N = 1'b0;
        #1;
        check("arst_rdy",  {31'd0, RDY}, 32'd1);
        check("arst_ce",   {31'd0, CE_OUT}, 32'd0);
        check("arst_si",   {31'd0, SI_OUT}, 32'd0);
        check("arst_cnt",  {24'd0, WORD_CNT}, 32'd0);
        @(posedge C);
        #1;
        CLR_N = 1'b1;
        check("arst_no_done", done_cnt, 32'd0);
        clear_stats();
        send(8'h81);
        tick(12);
        check("arst_next_stream", stream[7:0], 32'h81);
        check("arst_next_done",   done_cnt, 32'd1);
        check("arst_next_cnt",    {24'd0, WORD_CNT}, 32'd1);

        // LOAD while busy is ignored.
        clear_stats();
        send(8'h55);
        tick(2);
        DIN  = 8'h00;
        LOAD = 1'b1;
        tick(1);
        LOAD = 1'b0;
        tick(12);
        check("ign_stream", stream[7:0], 32'h55);
        check("ign_ce",     ce_cnt, 32'd8);
        check("ign_done",   done_cnt, 32'd1);
        check("ign_cnt",    {24'd0, WORD_CNT}, 32'd2);

        // 256 back-to-back words wrap the word counter.
        do_reset();
        clear_stats();
        for (int i = 0; i < 256; i++) begin
            send(8'(i * 37 + 1));
        end
        tick(12);
        check("wrap_done", done_cnt, 32'd256);
        check("wrap_ce_run", run_max, 32'd2048);
        check("wrap_cnt", {24'd0, WORD_CNT}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
